prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader_if.sv | 21 ++
 rtl/prog_loader_ram.sv | 25 ++
 rtl/prog_loader.sv | 165 ++++++++++++++++
 tb/tb_prog_loader.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader shared definitions
// loader states, image framing constants and the fetch fill word
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader byte stream interface
// valid/ready byte handshake from the serial receiver
interface prog_loader_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/prog_loader_ram.sv
// prog_ram: program word store
// one synchronous write port, one asynchronous read port
module prog_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_W)-1];

  // array is left unreset; the loader masks stale words
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_loader.sv
// prog_loader: serial program image loader
// fills program RAM from a byte stream, then releases the CPU
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      rx,
  input  logic              reload,
  input  logic [31:0]       program_addr_bus,
  output logic [31:0]       program_data_bus,
  output logic              cpu_reset,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] W_ONE = 1;
  localparam logic [ADDR_W:0] W_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0] LAST_B = 2'(BYTES_PER_WORD - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0]     r_len;
  logic [1:0]      r_cnt;
  logic [23:0]     r_asm;
  logic [ADDR_W:0] r_words;
  logic            r_cpu_rst;

  logic              w_ready;
  logic              w_acc;
  logic [15:0]       w_hdr_n;
  logic              w_last_byte;
  logic              w_we;
  logic [ADDR_W:0]   w_words_inc;
  logic              w_done;
  logic [31:0]       w_wdata;
  logic [ADDR_W-1:0] w_raddr;
  logic [31:0]       w_rdata;
  logic              w_hit;

  assign w_ready = (r_state == S_LEN_LO)
                 | (r_state == S_LEN_HI)
                 | (r_state == S_DATA);

  assign rx.rx_ready = w_ready;
  assign w_acc = rx.rx_valid & w_ready;

  assign w_hdr_n = {rx.rx_data, r_len[7:0]};

  assign w_last_byte = (r_state == S_DATA)
                     & w_acc
                     & (r_cnt == LAST_B);

  assign w_we = w_last_byte & ~reload;

  assign w_words_inc = (r_words == W_MAX)
                     ? r_words
                     : r_words + W_ONE;

  assign w_done  = (32'(w_words_inc) == 32'(r_len));
  assign w_wdata = {rx.rx_data, r_asm};

  // next-state: reload beats every other transition
  always_comb begin
    w_state_nxt = r_state;
    if (reload) begin
      w_state_nxt = S_LEN_LO;
    end else begin
      unique case (r_state)
        S_LEN_LO: begin
          if (w_acc) w_state_nxt = S_LEN_HI;
        end
        S_LEN_HI: begin
          if (w_acc) begin
            if (w_hdr_n == 16'd0)
              w_state_nxt = S_RUN;
            else if (32'(w_hdr_n) > DEPTH)
              w_state_nxt = S_ERR;
            else
              w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (w_last_byte && w_done)
            w_state_nxt = S_RUN;
        end
        S_RUN: ;
        S_ERR: ;
        default: w_state_nxt = S_LEN_LO;
      endcase
    end
  end

  // state register and registered CPU release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_LEN_LO;
      r_cpu_rst <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cpu_rst <= (w_state_nxt == S_RUN);
    end
  end

  // header capture, byte assembly and word count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len   <= '0;
      r_cnt   <= '0;
      r_asm   <= '0;
      r_words <= '0;
    end else if (reload) begin
      r_len   <= '0;
      r_cnt   <= '0;
      r_asm   <= '0;
      r_words <= '0;
    end else if (w_acc) begin
      unique case (r_state)
        S_LEN_LO: r_len[7:0]  <= rx.rx_data;
        S_LEN_HI: r_len[15:8] <= rx.rx_data;
        S_DATA: begin
          if (r_cnt == LAST_B) begin
            r_cnt   <= '0;
            r_words <= w_words_inc;
          end else begin
            unique case (r_cnt)
              2'd0: r_asm[7:0]   <= rx.rx_data;
              2'd1: r_asm[15:8]  <= rx.rx_data;
              default: r_asm[23:16] <= rx.rx_data;
            endcase
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_raddr = program_addr_bus[ADDR_W+1:2];

  assign w_hit = ((program_addr_bus >> (ADDR_W + 2)) == 32'd0)
               && ({1'b0, w_raddr} < r_words);

  prog_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_words[ADDR_W-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign program_data_bus = w_hit ? w_rdata : NOP_WORD;
  assign cpu_reset        = r_cpu_rst;
  assign load_err         = (r_state == S_ERR);
  assign words_loaded     = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized + directed bench
// byte-stream model checked against the loader every cycle
module tb_prog_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        reload;
  logic [31:0] addr;
  logic [31:0] pdata;
  logic        cpu_reset;
  logic        load_err;
  logic [8:0]  words_loaded;

  prog_loader_if rx();

  prog_loader #(
    .ADDR_W   (8),
    .NOP_WORD (NOP)
  ) dut (
    .clk              (clk),
    .reset            (rst_n),
    .rx               (rx.slave),
    .reload           (reload),
    .program_addr_bus (addr),
    .program_data_bus (pdata),
    .cpu_reset        (cpu_reset),
    .load_err         (load_err),
    .words_loaded     (words_loaded)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: position in the byte stream decides meaning
  int          m_nb;
  int          m_len;
  int          m_words;
  logic [31:0] m_word;
  logic        m_run;
  logic        m_err;
  logic [31:0] m_mem [256];
  logic        m_ready;

  assign m_ready = !m_run && !m_err;

  always @(posedge clk or negedge rst_n) begin : model
    int k;
    int n;
    if (!rst_n || reload) begin
      m_nb    <= 0;
      m_len   <= 0;
      m_words <= 0;
      m_word  <= 0;
      m_run   <= 1'b0;
      m_err   <= 1'b0;
    end else if (rx.rx_valid && m_ready) begin
      m_nb <= m_nb + 1;
      if (m_nb == 0) begin
        m_len <= int'(rx.rx_data);
      end else if (m_nb == 1) begin
        n = int'(rx.rx_data) * 256 + m_len;
        m_len <= n;
        if (n == 0) m_run <= 1'b1;
        else if (n > 256) m_err <= 1'b1;
      end else begin
        k = m_nb - 2;
        if (k % 4 == 3) begin
          m_mem[k/4] <= m_word | (32'(rx.rx_data) << 24);
          m_words    <= k/4 + 1;
          m_word     <= 0;
          if (k/4 + 1 == m_len) m_run <= 1'b1;
        end else begin
          m_word <= m_word | (32'(rx.rx_data) << (8 * (k % 4)));
        end
      end
    end
  end

  function automatic logic [31:0] exp_fetch(input logic [31:0] a);
    int idx;
    if ((a >> 10) != 0) return NOP;
    idx = int'(a[9:2]);
    if (idx < m_words) return m_mem[idx];
    return NOP;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("rx_ready", 64'(rx.rx_ready), 64'(m_ready));
    chk("cpu_reset", 64'(cpu_reset), 64'(m_run));
    chk("load_err", 64'(load_err), 64'(m_err));
    chk("words_loaded", 64'(words_loaded), 64'(m_words));
    chk("fetch", 64'(pdata), 64'(exp_fetch(addr)));
  end

  // fetch address: random unless a directed check pins it
  logic        addr_rand = 1'b1;
  logic [31:0] addr_fix  = '0;

  always @(posedge clk) begin
    #2;
    if (!addr_rand) addr = addr_fix;
    else if ($urandom_range(0, 3) == 0) addr = $urandom;
    else addr = 32'($urandom_range(0, 32'h40f));
  end

  int gap = 0;
  bit gap_rand = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit rl = 1'b0);
    int  n;
    int  g;
    logic got;
    n = 0;
    rx.rx_valid = 1'b1;
    rx.rx_data  = b;
    reload      = rl;
    do begin
      got = rx.rx_ready;
      step();
      n++;
    end while (!got && n < 20);
    rx.rx_valid = 1'b0;
    reload      = 1'b0;
    rx.rx_data  = 8'($urandom);
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h not accepted in %0d cycles",
               b, n);
    end
    g = gap_rand ? int'($urandom_range(0, 2)) : gap;
    repeat (g) step();
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic fetch_chk(input string name,
                           input logic [31:0] a,
                           input logic [31:0] exp);
    addr_rand = 1'b0;
    addr_fix  = a;
    @(negedge clk);
    chk(name, 64'(pdata), 64'(exp));
    step();
    addr_rand = 1'b1;
  endtask

  task automatic send_image1();
    logic [7:0] img [10];
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10,
            8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    for (int i = 0; i < 9; i++) send(img[i]);
    chk("img_cpu_before_last", 64'(cpu_reset), 64'd0);
    chk("img_ready_before_last", 64'(rx.rx_ready), 64'd1);
    send(img[9]);
  endtask

  initial begin
    int n;
    bit abort;
    rst_n       = 1'b0;
    reload      = 1'b0;
    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'h00;
    addr        = '0;
    repeat (3) step();
    chk("reset_cpu", 64'(cpu_reset), 64'd0);
    chk("reset_words", 64'(words_loaded), 64'd0);
    chk("reset_err", 64'(load_err), 64'd0);
    chk("reset_ready", 64'(rx.rx_ready), 64'd1);
    rst_n = 1'b1;
    step();

    // basic image, continuous valid
    gap = 0;
    send_image1();
    chk("img1_cpu_rise", 64'(cpu_reset), 64'd1);
    chk("img1_words", 64'(words_loaded), 64'd2);
    chk("img1_model_w0", 64'(m_mem[0]), 64'h0010_0513);
    chk("img1_model_w1", 64'(m_mem[1]), 64'h0020_0593);
    fetch_chk("img1_f0", 32'h0, 32'h0010_0513);
    fetch_chk("img1_f4", 32'h4, 32'h0020_0593);
    fetch_chk("img1_f8", 32'h8, NOP);
    fetch_chk("img1_f6_lowbits", 32'h6, 32'h0020_0593);
    fetch_chk("img1_upper", 32'h0001_0004, NOP);

    // same image, valid every other cycle
    pulse_reload();
    chk("reload_cpu_low", 64'(cpu_reset), 64'd0);
    gap = 1;
    send_image1();
    gap = 0;
    chk("tog_cpu", 64'(cpu_reset), 64'd1);
    chk("tog_words", 64'(words_loaded), 64'd2);
    fetch_chk("tog_f0", 32'h0, 32'h0010_0513);
    fetch_chk("tog_f4", 32'h4, 32'h0020_0593);

    // oversize header
    pulse_reload();
    send(8'h01);
    send(8'h01);
    chk("err_flag", 64'(load_err), 64'd1);
    chk("err_ready", 64'(rx.rx_ready), 64'd0);
    chk("err_cpu", 64'(cpu_reset), 64'd0);
    rx.rx_valid = 1'b1;
    repeat (3) step();
    rx.rx_valid = 1'b0;
    chk("err_sticky", 64'(load_err), 64'd1);
    pulse_reload();
    chk("err_clear", 64'(load_err), 64'd0);
    chk("err_clear_ready", 64'(rx.rx_ready), 64'd1);

    // empty image
    send(8'h00);
    chk("empty_cpu_first", 64'(cpu_reset), 64'd0);
    send(8'h00);
    chk("empty_cpu", 64'(cpu_reset), 64'd1);
    fetch_chk("empty_f0", 32'h0, NOP);
    fetch_chk("empty_f4", 32'h4, NOP);

    // reload colliding with a data byte
    pulse_reload();
    send(8'h02);
    send(8'h00);
    send(8'hdd);
    send(8'hcc);
    send(8'hbb);
    send(8'haa);
    chk("coll_words_pre", 64'(words_loaded), 64'd1);
    send(8'h11);
    send(8'h22);
    send(8'h33, 1'b1);
    chk("coll_words", 64'(words_loaded), 64'd0);
    chk("coll_ready", 64'(rx.rx_ready), 64'd1);
    send(8'h01);
    send(8'h00);
    send(8'h44);
    send(8'h33);
    send(8'h22);
    send(8'h11);
    chk("coll_n1_words", 64'(words_loaded), 64'd1);
    chk("coll_n1_cpu", 64'(cpu_reset), 64'd1);
    fetch_chk("coll_f0", 32'h0, 32'h1122_3344);
    fetch_chk("coll_f4", 32'h4, NOP);

    // asynchronous reset mid-image
    pulse_reload();
    send(8'h03);
    send(8'h00);
    for (int i = 0; i < 5; i++) send(8'(i + 1));
    chk("areset_words_pre", 64'(words_loaded), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_cpu", 64'(cpu_reset), 64'd0);
    chk("areset_words", 64'(words_loaded), 64'd0);
    chk("areset_err", 64'(load_err), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // full-depth image, word count reaches 2^ADDR_W
    send(8'h00);
    send(8'h01);
    for (int i = 0; i < 1024; i++) send(8'($urandom));
    chk("full_words", 64'(words_loaded), 64'd256);
    chk("full_cpu", 64'(cpu_reset), 64'd1);
    fetch_chk("full_last", 32'h3fc, m_mem[255]);
    fetch_chk("full_beyond", 32'h400, NOP);

    // random images with random gaps and reload collisions
    gap_rand = 1'b1;
    for (int img = 0; img < 40; img++) begin
      pulse_reload();
      n = int'($urandom_range(0, 99));
      if (n < 8) n = int'($urandom_range(257, 65535));
      else if (n < 13) n = 0;
      else n = int'($urandom_range(1, 8));
      send(8'(n));
      send(8'(n >> 8));
      abort = 1'b0;
      if (n >= 1 && n <= 256) begin
        for (int i = 0; i < 4 * n && !abort; i++) begin
          if ($urandom_range(0, 99) < 3) begin
            send(8'($urandom), 1'b1);
            abort = 1'b1;
          end else begin
            send(8'($urandom));
          end
        end
      end
      if (!abort) begin
        rx.rx_valid = 1'b1;
        repeat (2) step();
        rx.rx_valid = 1'b0;
      end
      repeat (4) step();
    end

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
